// File: rtl/simon_pkg.sv
// Shared definitions for the Simon key schedule: z constant sequences, parameter
// legality check and the expander FSM state type.
package simon_pkg;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    function automatic logic [61:0] rev62(input logic [61:0] x);
        logic [61:0] r;
        for (int j = 0; j < 62; j++) begin
            r[j] = x[61-j];
        end
        return r;
    endfunction

    // Literals are written element 0 first; reversed so bit j holds element j.
    localparam logic [61:0] Z_SEQ [5] = '{
        rev62(62'b11111010001001010110000111001101111101000100101011000011100110),
        rev62(62'b10001110111110010011000010110101000111011111001001100001011010),
        rev62(62'b10101111011100000011010010011000101000010001111110010110110011),
        rev62(62'b11011011101011000110010111100000010010001010011100110100001111),
        rev62(62'b11010001111001101011011000100000010111000011001010010011101111)
    };

    function automatic bit params_legal(input int w, input int m, input int t, input int z);
        return (w inside {16, 24, 32, 48, 64}) && (m inside {2, 3, 4}) && (t >= m) &&
               (z >= 0) && (z <= 4);
    endfunction

endpackage

// File: rtl/simon_key_round.sv
// Combinational Simon key-expansion step: derives k[i+m] from the current key window.
module simon_key_round #(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4
) (
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] wm1,
    input  logic              z_bit,
    output logic [WORD_W-1:0] new_word
);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int r);
        return (x >> r) | (x << (WORD_W - r));
    endfunction

    logic [WORD_W-1:0] tmp;

    always_comb begin
        tmp = rotr(wm1, 3);
        if (KEY_WORDS == 4) begin
            tmp = tmp ^ w1;
        end
        tmp = tmp ^ rotr(tmp, 1);
        new_word = ~w0 ^ tmp ^ WORD_W'(3) ^ {{(WORD_W-1){1'b0}}, z_bit};
    end

endmodule

// File: rtl/simon_key_sched.sv
// Simon key-expansion engine streaming round keys over valid/ready.
// Define SIMON_KEY_SCHED_STORE_EN to also keep every emitted key in a readable RAM.
module simon_key_sched
    import simon_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 32,
    parameter int Z_IDX     = 0,
    localparam int IDX_W    = $clog2(ROUNDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          rk_valid,
    input  logic                          rk_ready,
`ifdef SIMON_KEY_SCHED_STORE_EN
    input  logic [IDX_W-1:0]              rd_addr,
    input  logic                          rd_en,
    output logic [WORD_W-1:0]             rd_data,
`endif
    output logic [IDX_W-1:0]              rk_idx,
    output logic [WORD_W-1:0]             rk_data
);

    if (!params_legal(WORD_W, KEY_WORDS, ROUNDS, Z_IDX)) begin : g_bad_params
        $error("simon_key_sched: illegal parameter combination");
    end

    state_e            state_q;
    logic [WORD_W-1:0] win_q [KEY_WORDS];
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] data_q;
    logic              valid_q, busy_q, done_q;
    logic [5:0]        zcnt_q;
    logic [WORD_W-1:0] gen_word;
    logic [WORD_W-1:0] win_next;

    simon_key_round #(
        .WORD_W   (WORD_W),
        .KEY_WORDS(KEY_WORDS)
    ) u_round (
        .w0      (win_q[0]),
        .w1      (win_q[1]),
        .wm1     (win_q[KEY_WORDS-1]),
        .z_bit   (Z_SEQ[Z_IDX][zcnt_q]),
        .new_word(gen_word)
    );

    // Master-key word following the current index, while still inside the loaded key.
    always_comb begin
        win_next = win_q[0];
        for (int j = 0; j < KEY_WORDS; j++) begin
            if (int'(idx_q) + 1 == j) win_next = win_q[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            for (int j = 0; j < KEY_WORDS; j++) win_q[j] <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zcnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int j = 0; j < KEY_WORDS; j++) win_q[j] <= key_in[j*WORD_W +: WORD_W];
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        data_q  <= key_in[WORD_W-1:0];
                        zcnt_q  <= '0;
                    end
                end
                StRun: begin
                    if (rk_ready) begin
                        if (idx_q == IDX_W'(ROUNDS - 1)) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            if (idx_q < IDX_W'(KEY_WORDS - 1)) begin
                                data_q <= win_next;
                            end else begin
                                data_q <= gen_word;
                                for (int j = 0; j < KEY_WORDS - 1; j++) win_q[j] <= win_q[j+1];
                                win_q[KEY_WORDS-1] <= gen_word;
                                zcnt_q <= (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rk_valid = valid_q;
    assign rk_idx   = idx_q;
    assign rk_data  = data_q;

`ifdef SIMON_KEY_SCHED_STORE_EN
    // Key store survives reset; unwritten entries return whatever an earlier run left.
    logic [WORD_W-1:0] mem_q [ROUNDS];
    logic [WORD_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (valid_q && rk_ready) mem_q[idx_q] <= data_q;
        if (rd_en) rd_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_q;
`else
    // Pure streaming: emitted keys are not retained.
`endif

endmodule

// File: tb/tb_simon_key_sched.sv
// Self-checking bench for simon_key_sched against an array-based key schedule model.
module tb_simon_key_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default instance: 16/4, 32 rounds, z0
    logic [63:0] key0 = '0;
    logic        start0 = 1'b0, ready0 = 1'b1;
    logic        busy0, done0, valid0;
    logic [4:0]  idx0;
    logic [15:0] data0;
`ifdef SIMON_KEY_SCHED_STORE_EN
    logic        rd_en0 = 1'b0;
    logic [4:0]  rd_addr0 = '0;
    logic [15:0] rd_data0;
`endif

    // 64/2, 68 rounds, z2
    logic [127:0] key1 = '0;
    logic         start1 = 1'b0, ready1 = 1'b1;
    logic         busy1, done1, valid1;
    logic [6:0]   idx1;
    logic [63:0]  data1;

    // 24/3, 36 rounds, z1
    logic [71:0]  key2 = '0;
    logic         start2 = 1'b0, ready2 = 1'b1;
    logic         busy2, done2, valid2;
    logic [5:0]   idx2;
    logic [23:0]  data2;

    simon_key_sched u_d0 (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key0),
        .start   (start0),
        .busy    (busy0),
        .done    (done0),
        .rk_valid(valid0),
        .rk_ready(ready0),
`ifdef SIMON_KEY_SCHED_STORE_EN
        .rd_addr (rd_addr0),
        .rd_en   (rd_en0),
        .rd_data (rd_data0),
`endif
        .rk_idx  (idx0),
        .rk_data (data0)
    );

    simon_key_sched #(.WORD_W(64), .KEY_WORDS(2), .ROUNDS(68), .Z_IDX(2)) u_d1 (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key1),
        .start   (start1),
        .busy    (busy1),
        .done    (done1),
        .rk_valid(valid1),
        .rk_ready(ready1),
`ifdef SIMON_KEY_SCHED_STORE_EN
        .rd_addr (7'd0),
        .rd_en   (1'b0),
        .rd_data (),
`endif
        .rk_idx  (idx1),
        .rk_data (data1)
    );

    simon_key_sched #(.WORD_W(24), .KEY_WORDS(3), .ROUNDS(36), .Z_IDX(1)) u_d2 (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key2),
        .start   (start2),
        .busy    (busy2),
        .done    (done2),
        .rk_valid(valid2),
        .rk_ready(ready2),
`ifdef SIMON_KEY_SCHED_STORE_EN
        .rd_addr (6'd0),
        .rd_en   (1'b0),
        .rd_data (),
`endif
        .rk_idx  (idx2),
        .rk_data (data2)
    );

    // z sequences as published, element 0 first
    string z_str [5] = '{
        "11111010001001010110000111001101111101000100101011000011100110",
        "10001110111110010011000010110101000111011111001001100001011010",
        "10101111011100000011010010011000101000010001111110010110110011",
        "11011011101011000110010111100000010010001010011100110100001111",
        "11010001111001101011011000100000010111000011001010010011101111"
    };

    logic [63:0] exp_k [128];
    logic [63:0] got   [128];

    function automatic logic [63:0] rotr_n(input logic [63:0] x, input int r, input int n);
        logic [63:0] mask;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        return ((x >> r) | (x << (n - r))) & mask;
    endfunction

    task automatic gen_model(input int n, input int m, input int t, input int zi,
                             input logic [255:0] key);
        logic [63:0] mask, tmp;
        logic        zb;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        for (int j = 0; j < m; j++) exp_k[j] = 64'(key >> (j * n)) & mask;
        for (int i = 0; i + m < t; i++) begin
            tmp = rotr_n(exp_k[i+m-1], 3, n);
            if (m == 4) tmp = tmp ^ exp_k[i+1];
            tmp = tmp ^ rotr_n(tmp, 1, n);
            zb  = (z_str[zi][i % 62] == "1");
            exp_k[i+m] = (~exp_k[i] ^ tmp ^ 64'd3 ^ {63'd0, zb}) & mask;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consume nkeys keys from the default instance, optionally stalling and poking start/key_in.
    task automatic run0(input int nkeys, input bit stalls, input bit poke);
        int idx   = 0;
        int guard = 0;
        while (idx < nkeys) begin
            ready0 = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (poke && idx == 5) begin
                start0 = 1'b1;
                key0   = {$urandom, $urandom};
            end else begin
                start0 = 1'b0;
            end
            chk("d0 valid", 64'(valid0), 64'd1);
            chk("d0 busy", 64'(busy0), 64'd1);
            chk("d0 idx", 64'(idx0), 64'(idx));
            chk("d0 data", 64'(data0), exp_k[idx]);
            got[idx] = 64'(data0);
            step();
            if (ready0) idx++;
            guard++;
            if (guard > 2000) begin
                total++;
                bad++;
                $error("FAIL d0 stream timeout at idx %0d", idx);
                break;
            end
        end
        start0 = 1'b0;
        ready0 = 1'b1;
    endtask

    task automatic check_done0();
        chk("d0 done pulse", 64'(done0), 64'd1);
        chk("d0 valid at done", 64'(valid0), 64'd0);
        chk("d0 busy at done", 64'(busy0), 64'd0);
    endtask

    initial begin
        logic [63:0] k3;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst done", 64'(done0), 64'd0);
        chk("rst valid", 64'(valid0), 64'd0);
        chk("rst idx", 64'(idx0), 64'd0);
        chk("rst data", 64'(data0), 64'd0);
        rst = 1'b0;

        // Known vector, full speed; key_in change and start during busy must be ignored
        key0 = 64'h1918111009080100;
        gen_model(16, 4, 32, 0, {192'd0, key0});
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run0(32, 1'b0, 1'b1);
        check_done0();
        chk("k0 known", got[0], 64'h0100);
        chk("k3 known", got[3], 64'h1918);
        chk("k4 known", got[4], 64'h71C3);

        // Restart in the done cycle, same key, random backpressure
        key0   = 64'h1918111009080100;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("d0 done one cycle", 64'(done0), 64'd0);
        run0(32, 1'b1, 1'b0);
        check_done0();

`ifdef SIMON_KEY_SCHED_STORE_EN
        rd_addr0 = 5'd4;
        rd_en0   = 1'b1;
        step();
        rd_en0 = 1'b0;
        chk("store rd k4", 64'(rd_data0), 64'h71C3);
`endif

        // Reset mid-run at idx 10, then restart
        k3   = {$urandom, $urandom};
        key0 = k3;
        gen_model(16, 4, 32, 0, {192'd0, k3});
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run0(10, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst valid", 64'(valid0), 64'd0);
        chk("midrst busy", 64'(busy0), 64'd0);
        chk("midrst idx", 64'(idx0), 64'd0);
        chk("midrst data", 64'(data0), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midrst no done", 64'(done0), 64'd0);
        end
        rst = 1'b0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        run0(32, 1'b0, 1'b0);
        check_done0();

        // 64/2 with 68 rounds: z index wraps past 61
        key1 = {$urandom, $urandom, $urandom, $urandom};
        gen_model(64, 2, 68, 2, {128'd0, key1});
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 68; i++) begin
            chk("d1 valid", 64'(valid1), 64'd1);
            chk("d1 idx", 64'(idx1), 64'(i));
            chk("d1 data", data1, exp_k[i]);
            step();
        end
        chk("d1 done", 64'(done1), 64'd1);
        chk("d1 busy at done", 64'(busy1), 64'd0);

        // 24/3 with 36 rounds
        key2 = 72'({$urandom, $urandom, $urandom});
        gen_model(24, 3, 36, 1, {184'd0, key2});
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 36; i++) begin
            chk("d2 valid", 64'(valid2), 64'd1);
            chk("d2 idx", 64'(idx2), 64'(i));
            chk("d2 data", 64'(data2), exp_k[i]);
            step();
        end
        chk("d2 done", 64'(done2), 64'd1);
        chk("d2 valid at done", 64'(valid2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_key_sched.md
Name: simon_key_sched

Overview:
- Parametrised Simon key-expansion engine covering all Simon word/key sizes with a start/busy/done control handshake.
- Streams round keys over a valid/ready interface with backpressure, one key per cycle.
- Sits between the key-load register and the round pipeline, and replaces the fixed 32/64, free-running expander.

Parameters:
- WORD_W, 16: word size n; legal values 16, 24, 32, 48, 64.
- KEY_WORDS, 4: key words m; legal values 2, 3, 4.
- ROUNDS, 32: total round keys T emitted; must be >= KEY_WORDS.
- Z_IDX, 0: constant sequence select z0..z4; legal values 0..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- key_in  in  KEY_WORDS*WORD_W  master key; k[0] = key_in[WORD_W-1:0], k[j] is word j
- start  in  1  request expansion; sampled only when busy=0
- busy  out  1  high from the cycle after start is accepted until the last key handshake
- done  out  1  one-cycle pulse after the last key handshake
- rk_valid  out  1  rk_data/rk_idx are valid
- rk_ready  in  1  consumer accepts the key
- rk_idx  out  $clog2(ROUNDS)  round index of rk_data
- rk_data  out  WORD_W  round key k[rk_idx]

Behaviour:
- Reset (async, immediate): busy=0, done=0, rk_valid=0, rk_idx=0, rk_data=0, window cleared, FSM=IDLE.
- FSM states: IDLE, RUN.
  - IDLE & start: latch key_in into window w[0..m-1] = k[0..m-1]; go to RUN. rk_valid rises the next cycle with rk_idx=0, rk_data=k[0]. Latency from start to first key is 1 cycle.
  - RUN: a handshake (rk_valid & rk_ready) advances the index.
    - Idx < m-1: the next output is k[idx+1] from the window.
    - Otherwise the output is the generated word, and the window shifts by one: w[0..m-2] <= w[1..m-1], w[m-1] <= new.
  - RUN & handshake at idx = ROUNDS-1: next cycle is IDLE, done=1, rk_valid=0, busy=0.
- Backpressure: while rk_valid & !rk_ready, rk_data and rk_idx are held stable. No key is skipped or duplicated.
- Throughput: one key per cycle under continuous rk_ready.
- Generation for k[i+m], i = 0.., with rotr as rotate right within WORD_W bits:
  - tmp = rotr(w[m-1], 3)
  - if m = 4: tmp ^= w[1]
  - tmp ^= rotr(tmp, 1)
  - new = ~w[0] ^ tmp ^ 3 ^ z[Z_IDX][i mod 62]
  - The z bit is in bit 0 only.
- z index: a 6-bit counter increments on each generated key and wraps 61 -> 0.
- start while busy=1 is ignored. start in the done cycle is accepted, because FSM=IDLE.
- Changes on key_in after acceptance have no effect.
- Reset mid-run: outputs drop immediately; no done pulse.
- Illegal parameter combinations: elaboration-time $error.

Optional Feature:
- Macro SIMON_KEY_SCHED_STORE_EN.
- Defined:
  - Adds inputs rd_addr ($clog2(ROUNDS)) and rd_en (1), and output rd_data (WORD_W).
  - Every emitted key is also written to an internal ROUNDS x WORD_W RAM at rk_idx on handshake.
  - rd_data is registered, with 1-cycle latency after rd_en.
  - Reading an address not yet written this run returns the previous contents.
  - The RAM is not cleared by rst.
- Undefined: no RAM and no rd_* ports. Pure streaming.

Decomposition:
- Package simon_pkg:
  - Z_SEQ[5] of 62-bit constants; bit j = j-th element of sequence z_k.
  - Legal-parameter check function.
  - Typedef of the FSM state enum.
- One sub-module, simon_key_round:
  - Combinational next-word function.
  - Inputs: window words w[0], w[1], w[m-1] and z bit.
  - Parametrised on WORD_W and KEY_WORDS.
  - Reused by the round pipeline's on-the-fly mode.

Test Plan:
- Defaults, key_in=64'h1918111009080100, rk_ready=1: keys 0..3 = 0100, 0908, 1110, 1918; k[4]=16'h71C3; 32 keys total, compared against the reference model; done 1 cycle after idx 31.
- Random rk_ready toggling: rk_data/rk_idx stable while stalled; the sequence is identical to the no-stall run.
- Assert rst in RUN at idx 10: all outputs 0 in the same cycle, no done; a restart produces the correct full sequence.
- start during busy and a key_in change mid-run: ignored. start in the done cycle: new run begins; first key valid next cycle.
- WORD_W=64, KEY_WORDS=2, ROUNDS=68, Z_IDX=2, and WORD_W=24, KEY_WORDS=3, ROUNDS=36, Z_IDX=1: all keys match the model, including z wrap at i=62.
- With SIMON_KEY_SCHED_STORE_EN, after a default run: rd_addr=4 -> rd_data=16'h71C3 one cycle after rd_en.
